// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Requester IDs; these are also the values driven on sel
  localparam logic REQ_IF = 1'b0;  // instruction fetch
  localparam logic REQ_DM = 1'b1;  // data access

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker. Purely combinational, so any two-port arbiter can reuse it.
module rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       winner
);

  // A lone requester wins outright; on a tie, the one not served last wins
  always_comb begin
    grant_valid = |req;
    winner      = REQ_IF;
    if (req == 2'b11)
      winner = ~last;
    else if (req[1])
      winner = REQ_DM;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (0) and data access (1).
// Latches the winning request, waits for mem_ready or a timeout, and returns a
// one-cycle ack/err pulse to the owner. All outputs are registered.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic             we0,
  input  logic             we1,
  output logic             ack0,
  output logic             ack1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] rdata,
  output logic             sel,
  output logic             mem_valid,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT);

  state_e        state, state_nx;
  logic          last;
  logic [CW-1:0] wait_cnt;
  logic [1:0]    eff_req;
  logic          grant_valid, winner;
  logic          cnt_last;

  // A requester showing its ack/err pulse is masked so it is not re-granted
  // while it is still dropping req.
  assign eff_req  = {req1 & ~ack1 & ~err1, req0 & ~ack0 & ~err0};
  assign cnt_last = (wait_cnt == CW'(TIMEOUT - 1));

  rr_pick2 u_pick (
    .req         (eff_req),
    .last        (last),
    .grant_valid (grant_valid),
    .winner      (winner)
  );

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: grant from IDLE, leave BUSY on ready or on the final count
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (grant_valid)           state_nx = BUSY;
      BUSY: if (mem_ready || cnt_last) state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  // Port request follows the state register, so it drops with async reset
  assign mem_valid = (state == BUSY);

  // Registered datapath and owner pulses; ready on the final count is an ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= REQ_IF;
      last      <= REQ_DM;
      wait_cnt  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rdata     <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err0 <= 1'b0;
      err1 <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            sel       <= winner;
            mem_addr  <= winner ? addr1  : addr0;
            mem_wdata <= winner ? wdata1 : wdata0;
            mem_we    <= winner ? we1    : we0;
            wait_cnt  <= '0;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (sel) ack1 <= 1'b1;
            else     ack0 <= 1'b1;
            rdata <= mem_rdata;
            last  <= sel;
          end else if (cnt_last) begin
            if (sel) err1 <= 1'b1;
            else     err0 <= 1'b1;
            last <= sel;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single read, round-robin tie, ack
// masking, timeout, ready on the final count and reset during BUSY.
module tb_mem_port_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1, we0, we1;
  logic [W-1:0] addr0, addr1, wdata0, wdata1;
  logic         ack0, ack1, err0, err1;
  logic [W-1:0] rdata;
  logic         sel, mem_valid, mem_we;
  logic [W-1:0] mem_addr, mem_wdata;
  logic         mem_ready;
  logic [W-1:0] mem_rdata;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WIDTH(W), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .we0(we0), .we1(we1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata(rdata), .sel(sel), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // advance one rising edge and settle 1 ns past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int bad;

  initial begin
    rst_n = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    mem_ready = 0; mem_rdata = '0;

    // ---------- reset state ----------
    #12;
    chk("rst_sel", sel, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_err", {err1, err0}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    step();

    // ---------- single read ----------
    req0 = 1; addr0 = 32'h0000_0040; we0 = 0; wdata0 = 32'h1234_5678;
    step();                                   // grant
    chk("rd_mem_valid", mem_valid, 1);
    chk("rd_mem_addr", mem_addr, 32'h40);
    chk("rd_sel", sel, 0);
    chk("rd_mem_we", mem_we, 0);
    addr0 = 32'hFFFF_0000;                     // owner inputs ignored once latched
    step();                                   // first BUSY edge, no ready
    chk("rd_busy_valid", mem_valid, 1);
    chk("rd_busy_ack", ack0, 0);
    chk("rd_busy_addr", mem_addr, 32'h40);
    mem_ready = 1; mem_rdata = 32'hDEAD_BEEF;
    step();                                   // completion
    chk("rd_ack0", ack0, 1);
    chk("rd_rdata", rdata, 32'hDEAD_BEEF);
    chk("rd_done_valid", mem_valid, 0);
    chk("rd_others", {ack1, err1, err0}, 0);
    req0 = 0; mem_ready = 0;
    step();
    chk("rd_ack_1cyc", ack0, 0);
    chk("rd_idle_valid", mem_valid, 0);

    // ---------- simultaneous requests from reset ----------
    rst_n = 0; #3; rst_n = 1;
    req0 = 1; req1 = 1; addr0 = 32'h100; addr1 = 32'h200; we0 = 0; we1 = 0;
    mem_ready = 1;
    for (int t = 0; t < 4; t++) begin
      mem_rdata = 32'hA000_0000 + t;
      step();                                 // grant
      chk($sformatf("rr_sel_%0d", t), sel, t % 2);
      chk($sformatf("rr_addr_%0d", t), mem_addr, (t % 2) ? 32'h200 : 32'h100);
      chk($sformatf("rr_valid_%0d", t), mem_valid, 1);
      step();                                 // completion
      chk($sformatf("rr_ack_%0d", t), {ack1, ack0}, (t % 2) ? 2'b10 : 2'b01);
      chk($sformatf("rr_rdata_%0d", t), rdata, 32'hA000_0000 + t);
    end
    req0 = 0; req1 = 0;
    step();
    chk("rr_idle", mem_valid, 0);

    // ---------- ack masking (write, req1 only) ----------
    req1 = 1; we1 = 1; addr1 = 32'h300; wdata1 = 32'h0000_CAFE;
    mem_ready = 1; mem_rdata = 32'h55;
    step();
    chk("am_sel", sel, 1);
    chk("am_we", mem_we, 1);
    chk("am_wdata", mem_wdata, 32'hCAFE);
    step();
    chk("am_ack1", ack1, 1);
    chk("am_rdata_wr", rdata, 32'h55);
    step();                                   // req1 still high, masked by ack1
    chk("am_no_regrant", mem_valid, 0);
    chk("am_ack_low", ack1, 0);
    req1 = 0;
    step();
    chk("am_still_idle", mem_valid, 0);

    // ---------- timeout with pending req0 ----------
    mem_ready = 0; req1 = 1; we1 = 1; addr1 = 32'h400;
    step();                                   // grant 1
    chk("to_sel", sel, 1);
    req0 = 1; addr0 = 32'h500; we0 = 0;
    bad = 0;
    for (int i = 0; i < 15; i++) begin        // BUSY edges with wait_cnt 0..14
      step();
      if (mem_valid !== 1'b1 || err1 !== 1'b0 || sel !== 1'b1) bad++;
    end
    chk("to_busy_15", bad, 0);
    step();                                   // 16th BUSY cycle ends
    chk("to_err1", err1, 1);
    chk("to_ack1", ack1, 0);
    chk("to_rdata_kept", rdata, 32'h55);
    chk("to_valid", mem_valid, 0);
    req1 = 0;
    step();                                   // pending req0 granted
    chk("to_pend_sel", sel, 0);
    chk("to_pend_addr", mem_addr, 32'h500);
    chk("to_pend_valid", mem_valid, 1);
    chk("to_err_1cyc", err1, 0);
    mem_ready = 1; mem_rdata = 32'h66;
    step();
    chk("to_pend_ack0", ack0, 1);
    req0 = 0; mem_ready = 0;
    step();

    // ---------- ready on the final count ----------
    req0 = 1; addr0 = 32'h600;
    step();                                   // grant 0
    steps(15);                                // wait_cnt reaches 15
    chk("fc_busy", mem_valid, 1);
    mem_ready = 1; mem_rdata = 32'h77;
    step();
    chk("fc_ack0", ack0, 1);
    chk("fc_err0", err0, 0);
    chk("fc_rdata", rdata, 32'h77);
    req0 = 0; mem_ready = 0;
    step();

    // ---------- reset mid-BUSY ----------
    req1 = 1; addr1 = 32'h700;
    step();
    chk("rb_busy", {mem_valid, sel}, 2'b11);
    #2 rst_n = 0;
    #1;
    chk("rb_valid", mem_valid, 0);
    chk("rb_sel", sel, 0);
    chk("rb_ack", {ack1, ack0}, 0);
    req0 = 1; addr0 = 32'h800; mem_ready = 1; mem_rdata = 32'h88;
    #1 rst_n = 1;
    step();
    chk("rb_tie_sel", sel, 0);
    chk("rb_tie_addr", mem_addr, 32'h800);
    step();
    chk("rb_tie_ack0", {ack1, ack0}, 2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
